// File: rtl/packet_generator_pkg.sv
// Shared definitions for the AXI-Stream packet generator: bus geometry, FSM
// encoding and the byte-count helper shared with the receive-side counter.
package packet_generator_pkg;

    localparam int DATA_BYTES = 32;
    localparam int DATA_W     = 256;
    localparam int BEAT_W     = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Number of valid bytes in one beat.
    function automatic logic [5:0] keep_popcount(input logic [DATA_BYTES-1:0] keep);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            cnt = cnt + {5'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_tkeep_gen.sv
// Byte-valid mask for one beat: full on inner beats, low `rem` bytes on the
// final beat of a packet whose length is not a multiple of the bus width.
module axis_tkeep_gen
    import packet_generator_pkg::*;
(
    input  logic [4:0]            rem,
    input  logic                  last,
    output logic [DATA_BYTES-1:0] tkeep
);

    // Mask decode
    always_comb begin
        tkeep = {DATA_BYTES{1'b1}};
        if (last && (rem != 5'd0)) begin
            tkeep = (32'd1 << rem) - 32'd1;
        end else begin
            tkeep = {DATA_BYTES{1'b1}};
        end
    end

endmodule

// File: rtl/packet_generator.sv
// Generates runs of fixed-length counting-pattern packets on a 256-bit
// AXI-Stream master, with inter-packet gaps and running byte/packet totals.
module packet_generator
    import packet_generator_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  resent,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           packet_bytes,
    input  logic [7:0]            num_packets,
    output logic [DATA_W-1:0]     axisout_tdata,
    output logic [DATA_BYTES-1:0] axisout_tkeep,
    output logic                  axisout_tvalid,
    output logic                  axisout_tlast,
    input  logic                  axisout_tready,
    output logic                  busy,
    output logic [7:0]            packetcounter_output,
    output logic [31:0]           sevenseg,
    output logic [7:0]            digital_enable
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t                state_r;
    state_t                state_nx_s;
    logic [BEAT_W-1:0]     beat_r;
    logic [BEAT_W-1:0]     beat_nx_s;
    logic [BEAT_W-1:0]     beats_total_r;
    logic [BEAT_W-1:0]     beats_in_s;
    logic [BEAT_W-1:0]     beats_cfg_s;
    logic [4:0]            rem_r;
    logic [4:0]            rem_cfg_s;
    logic [7:0]            num_pkts_r;
    logic [7:0]            pkt_done_r;
    logic [7:0]            pkt_done_nx_s;
    logic                  stop_r;
    logic                  stop_nx_s;
    logic [15:0]           gap_cnt_r;
    logic [15:0]           gap_cnt_nx_s;
    logic                  load_cfg_s;
    logic                  accept_s;
    logic                  last_acc_s;
    logic                  run_end_s;
    logic                  last_nx_s;
    logic [DATA_BYTES-1:0] keep_beat_s;
    logic [DATA_BYTES-1:0] keep_nx_s;
    logic [DATA_W-1:0]     data_nx_s;

    logic                  tvalid_r;
    logic                  tlast_r;
    logic                  busy_r;
    logic [DATA_W-1:0]     tdata_r;
    logic [DATA_BYTES-1:0] tkeep_r;
    logic [7:0]            pkt_count_r;
    logic [31:0]           byte_count_r;

    // Beat count from the live inputs; 12 bits covers the 2048-beat maximum.
    assign beats_in_s = BEAT_W'(({1'b0, packet_bytes} + 17'd31) >> 5);

    assign accept_s   = tvalid_r & axisout_tready;
    assign last_acc_s = accept_s & tlast_r;
    assign run_end_s  = stop_r | stop |
                        ((num_pkts_r != 8'd0) && ((pkt_done_r + 8'd1) == num_pkts_r));

    // Geometry in effect for the next beat: live inputs while idle, latched otherwise
    always_comb begin
        beats_cfg_s = beats_total_r;
        rem_cfg_s   = rem_r;
        if (state_r == ST_IDLE) begin
            beats_cfg_s = beats_in_s;
            rem_cfg_s   = packet_bytes[4:0];
        end else begin
            beats_cfg_s = beats_total_r;
            rem_cfg_s   = rem_r;
        end
    end

    // Next-state and run bookkeeping
    always_comb begin
        state_nx_s    = state_r;
        beat_nx_s     = beat_r;
        pkt_done_nx_s = pkt_done_r;
        gap_cnt_nx_s  = gap_cnt_r;
        stop_nx_s     = stop_r;
        load_cfg_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stop_nx_s = 1'b0;
                if (start && (packet_bytes != 16'd0)) begin
                    state_nx_s    = ST_SEND;
                    beat_nx_s     = {BEAT_W{1'b0}};
                    pkt_done_nx_s = 8'd0;
                    load_cfg_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                stop_nx_s = stop_r | stop;
                if (last_acc_s) begin
                    beat_nx_s     = {BEAT_W{1'b0}};
                    pkt_done_nx_s = pkt_done_r + 8'd1;
                    if (run_end_s) begin
                        state_nx_s = ST_IDLE;
                        stop_nx_s  = 1'b0;
                    end else if (GAP_CYCLES == 0) begin
                        state_nx_s = ST_SEND;
                    end else begin
                        state_nx_s   = ST_GAP;
                        gap_cnt_nx_s = 16'd0;
                    end
                end else if (accept_s) begin
                    beat_nx_s = beat_r + 12'd1;
                end else begin
                    beat_nx_s = beat_r;
                end
            end
            ST_GAP: begin
                if (stop_r || stop) begin
                    state_nx_s = ST_IDLE;
                    stop_nx_s  = 1'b0;
                end else if (gap_cnt_r == GAP_LAST) begin
                    state_nx_s = ST_SEND;
                    beat_nx_s  = {BEAT_W{1'b0}};
                end else begin
                    gap_cnt_nx_s = gap_cnt_r + 16'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign last_nx_s = (beat_nx_s == (beats_cfg_s - 12'd1));

    axis_tkeep_gen u_tkeep_gen (
        .rem   (rem_cfg_s),
        .last  (last_nx_s),
        .tkeep (keep_beat_s)
    );

    // Beat payload: byte j of beat b carries (32*b + j) mod 256, masked by tkeep
    always_comb begin
        data_nx_s = {DATA_W{1'b0}};
        keep_nx_s = {DATA_BYTES{1'b0}};
        if (state_nx_s == ST_SEND) begin
            keep_nx_s = keep_beat_s;
            for (int j = 0; j < DATA_BYTES; j++) begin
                data_nx_s[8*j +: 8] = keep_beat_s[j] ? {beat_nx_s[2:0], 5'(j)} : 8'h00;
            end
        end else begin
            data_nx_s = {DATA_W{1'b0}};
            keep_nx_s = {DATA_BYTES{1'b0}};
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (resent) begin
            state_r       <= ST_IDLE;
            beat_r        <= {BEAT_W{1'b0}};
            beats_total_r <= {BEAT_W{1'b0}};
            rem_r         <= 5'd0;
            num_pkts_r    <= 8'd0;
            pkt_done_r    <= 8'd0;
            stop_r        <= 1'b0;
            gap_cnt_r     <= 16'd0;
        end else begin
            state_r    <= state_nx_s;
            beat_r     <= beat_nx_s;
            pkt_done_r <= pkt_done_nx_s;
            stop_r     <= stop_nx_s;
            gap_cnt_r  <= gap_cnt_nx_s;
            if (load_cfg_s) begin
                beats_total_r <= beats_in_s;
                rem_r         <= packet_bytes[4:0];
                num_pkts_r    <= num_packets;
            end
        end
    end

    // Stream output register stage; holds steady while the sink stalls
    always_ff @(posedge clk) begin
        if (resent) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tkeep_r  <= {DATA_BYTES{1'b0}};
            tdata_r  <= {DATA_W{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            tvalid_r <= (state_nx_s == ST_SEND);
            tlast_r  <= (state_nx_s == ST_SEND) && last_nx_s;
            tkeep_r  <= keep_nx_s;
            tdata_r  <= data_nx_s;
            busy_r   <= (state_nx_s != ST_IDLE);
        end
    end

    // Lifetime packet and byte totals
    always_ff @(posedge clk) begin
        if (resent) begin
            pkt_count_r  <= 8'd0;
            byte_count_r <= 32'd0;
        end else begin
            if (accept_s) begin
                byte_count_r <= byte_count_r + {26'd0, keep_popcount(tkeep_r)};
            end
            if (last_acc_s) begin
                pkt_count_r <= pkt_count_r + 8'd1;
            end
        end
    end

    assign axisout_tdata        = tdata_r;
    assign axisout_tkeep        = tkeep_r;
    assign axisout_tvalid       = tvalid_r;
    assign axisout_tlast        = tlast_r;
    assign busy                 = busy_r;
    assign packetcounter_output = pkt_count_r;
    assign sevenseg             = byte_count_r;
    assign digital_enable       = 8'hFF;

endmodule

// File: tb/tb_packet_generator.sv
// Randomised bench for packet_generator: a byte-level reference model queues
// the expected beats and a negedge monitor scores every accepted beat.
module tb_packet_generator;

    localparam int GAP = 2;

    logic         clk = 1'b0;
    logic         resent = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [15:0]  packet_bytes = 16'd0;
    logic [7:0]   num_packets = 8'd0;
    logic         tready = 1'b1;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic         tvalid;
    logic         tlast;
    logic         busy;
    logic [7:0]   pkt_cnt;
    logic [31:0]  sevenseg;
    logic [7:0]   digital_enable;

    packet_generator #(.GAP_CYCLES(GAP)) dut (
        .clk                  (clk),
        .resent               (resent),
        .start                (start),
        .stop                 (stop),
        .packet_bytes         (packet_bytes),
        .num_packets          (num_packets),
        .axisout_tdata        (tdata),
        .axisout_tkeep        (tkeep),
        .axisout_tvalid       (tvalid),
        .axisout_tlast        (tlast),
        .axisout_tready       (tready),
        .busy                 (busy),
        .packetcounter_output (pkt_cnt),
        .sevenseg             (sevenseg),
        .digital_enable       (digital_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        mon_e;
    logic [7:0]   exp_pkts = 8'd0;
    logic [31:0]  exp_bytes = 32'd0;
    int           checks = 0;
    int           errors = 0;
    int           rmode = 0;
    logic         in_gap = 1'b0;
    int           gap_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [255:0] prev_d = '0;
    logic [31:0]  prev_k = '0;
    logic         prev_l = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference packet: byte index i < nbytes is valid and carries i mod 256.
    task automatic push_packet(input int nbytes);
        int nb;
        nb = (nbytes + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            e.d = '0;
            e.k = '0;
            for (int j = 0; j < 32; j++) begin
                int idx;
                idx = 32 * b + j;
                if (idx < nbytes) begin
                    e.k[j]       = 1'b1;
                    e.d[8*j +: 8] = 8'(idx % 256);
                end
            end
            e.l = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    // Sink ready pattern: 0 always ready, 1 alternating, 2 random
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: tready = 1'b1;
            1: tready = ~tready;
            2: tready = 1'($urandom_range(0, 1));
            default: tready = 1'b0;
        endcase
    end

    // Monitor: totals, stall stability, gap length and beat contents
    always @(negedge clk) begin
        check("pkt_total", pkt_cnt, exp_pkts);
        check("byte_total", sevenseg, exp_bytes);
        if (prev_stall) begin
            check("hold_valid", tvalid, 1'b1);
            check("hold_data", tdata, prev_d);
            check("hold_keep", tkeep, prev_k);
            check("hold_last", tlast, prev_l);
        end
        if (resent) begin
            exp_q.delete();
            exp_pkts  = 8'd0;
            exp_bytes = 32'd0;
            in_gap    = 1'b0;
        end else begin
            if (!busy) in_gap = 1'b0;
            if (in_gap && tvalid) begin
                check("gap_len", gap_cnt, GAP);
                in_gap = 1'b0;
            end else if (in_gap) begin
                gap_cnt++;
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", tvalid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tdata", tdata, mon_e.d);
                    check("tkeep", tkeep, mon_e.k);
                    check("tlast", tlast, mon_e.l);
                    exp_bytes = exp_bytes + $countones(mon_e.k);
                    if (mon_e.l) begin
                        exp_pkts = exp_pkts + 8'd1;
                        in_gap   = 1'b1;
                        gap_cnt  = 0;
                    end
                end
            end
        end
        prev_stall = tvalid && !tready && !resent;
        prev_d = tdata;
        prev_k = tkeep;
        prev_l = tlast;
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic launch(input int nbytes, input int np, input int mode);
        @(posedge clk); #1;
        packet_bytes = 16'(nbytes);
        num_packets  = 8'(np);
        rmode        = mode;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        packet_bytes = 16'($urandom);
        num_packets  = 8'($urandom);
    endtask

    task automatic run_pkts(input int nbytes, input int np, input int mode, input bit poke);
        for (int p = 0; p < np; p++) push_packet(nbytes);
        launch(nbytes, np, mode);
        @(negedge clk);
        check("start_latency", tvalid, 1'b1);
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle(20000);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] base;
        int n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tkeep", tkeep, 32'd0);
        check("rst_tdata", tdata, 256'd0);
        check("rst_busy", busy, 1'b0);
        check("digital_enable", digital_enable, 8'hFF);
        @(posedge clk); #1 resent = 1'b0;

        run_pkts(64, 1, 0, 1'b0);
        check("two_beat_bytes", sevenseg, 32'd64);
        check("two_beat_pkts", pkt_cnt, 8'd1);
        check("two_beat_busy", busy, 1'b0);

        run_pkts(70, 2, 0, 1'b1);
        check("gap_run_bytes", sevenseg, 32'd204);

        run_pkts(100, 1, 1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_pkts(int'($urandom_range(1, 200)), int'($urandom_range(1, 3)), 2, 1'b0);
        end

        // Continuous run stopped while packet 5 is on the bus
        base = exp_pkts;
        repeat (5) push_packet(32);
        launch(32, 0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pkt_cnt == 8'(base + 8'd4) && tvalid) && n < 1000);
        check("stop_wait", tvalid, 1'b1);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_idle(200);
        check("stop_pkts", pkt_cnt, 8'(base + 8'd5));
        check("stop_queue", exp_q.size(), 0);
        repeat (6) begin
            @(negedge clk);
            check("stop_quiet", tvalid, 1'b0);
        end

        // Stop during the inter-packet gap of a continuous run
        base = exp_pkts;
        push_packet(40);
        launch(40, 0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pkt_cnt == 8'(base + 8'd1) && !tvalid) && n < 1000);
        check("gap_stop_wait", pkt_cnt, 8'(base + 8'd1));
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        check("gap_stop_busy", busy, 1'b0);
        check("gap_stop_valid", tvalid, 1'b0);
        check("gap_stop_queue", exp_q.size(), 0);

        // Zero-length request is ignored
        launch(0, 1, 0);
        repeat (4) begin
            @(negedge clk);
            check("zero_busy", busy, 1'b0);
            check("zero_valid", tvalid, 1'b0);
        end

        // Reset while beat 2 of a 4-beat packet is presented
        push_packet(128);
        launch(128, 1, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tvalid && tdata[7:0] == 8'd32) && n < 100);
        check("rst_wait", tdata[7:0], 8'd32);
        @(posedge clk); #1 resent = 1'b1;
        @(negedge clk);
        check("rst_beat2", tdata[7:0], 8'd64);
        @(posedge clk); #1 resent = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", tvalid, 1'b0);
        check("midrst_tdata", tdata, 256'd0);
        check("midrst_tkeep", tkeep, 32'd0);
        check("midrst_tlast", tlast, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_pkts", pkt_cnt, 8'd0);
        check("midrst_bytes", sevenseg, 32'd0);
        run_pkts(128, 1, 0, 1'b0);

        // Packet counter wrap
        @(posedge clk); #1 resent = 1'b1;
        @(posedge clk); #1 resent = 1'b0;
        run_pkts(32, 255, 0, 1'b0);
        check("wrap_255", pkt_cnt, 8'd255);
        run_pkts(32, 2, 0, 1'b0);
        check("wrap_1", pkt_cnt, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
